store_buffer: RTL and testbench

- Posted-write buffer directly downstream of the pipelined CPU's data-memory store port.
- Accepts store requests (enable, address, data, funct3) and steers bytes into 4-lane word writes.
- Queues them in a small FIFO and drains them to the data memory over a req/ack handshake.
- Stalls the CPU when the queue is full, or when a load hits a word still pending in the queue.

---
 rtl/store_buffer.sv | 199 +++++++++++++++++++
 tb/tb_store_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU store port and data memory: lane steering, FIFO, req/ack drain.
// Optional merging of stores into the youngest queued entry is enabled by defining STORE_COALESCE_EN.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [2:0]    cpu_funct3,
    output logic          cpu_stall,
    output logic          misalign_err,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic [CW-1:0] count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [2:0]    F3_SB   = 3'b000;
    localparam logic [2:0]    F3_SH   = 3'b001;
    localparam logic [2:0]    F3_SW   = 3'b010;

    logic [29:0]      addr_q  [DEPTH];
    logic [29:0]      addr_d  [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [31:0]      data_d  [DEPTH];
    logic [3:0]       be_q    [DEPTH];
    logic [3:0]       be_d    [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    tail_last;
    logic [CW-1:0]    count_q, count_d;

    logic             mem_req_q, mem_req_d;
    logic [29:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic             misalign_q, misalign_d;

    logic [29:0]      word;
    logic             st_legal;
    logic [3:0]       st_be;
    logic [31:0]      st_data;
    logic             full;
    logic             coalesce;
    logic             push;
    logic             pop;
    logic             hit;

    assign word      = cpu_addr[31:2];
    assign tail_last = tail_q - PW'(1);
    assign full      = (count_q == DEPTH_C);

    // NOTE: every variable driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        st_legal = 1'b0;
        st_be    = 4'b0000;
        st_data  = cpu_wdata;
        case (cpu_funct3)
            F3_SB: begin
                st_legal = 1'b1;
                st_be    = 4'b0001 << cpu_addr[1:0];
                st_data  = {4{cpu_wdata[7:0]}};
            end
            F3_SH: begin
                st_legal = ~cpu_addr[0];
                st_be    = 4'b0011 << cpu_addr[1:0];
                st_data  = {2{cpu_wdata[15:0]}};
            end
            F3_SW: begin
                st_legal = (cpu_addr[1:0] == 2'b00);
                st_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    // The youngest entry may absorb a store unless it is the head already presented to memory.
`ifdef STORE_COALESCE_EN
    assign coalesce = cpu_we && st_legal && (count_q > CW'(1)) && (addr_q[tail_last] == word);
`else
    assign coalesce = 1'b0;
`endif

    // Full is judged on the registered count; a same-cycle pop does not make room.
    assign push = cpu_we && st_legal && !full && !coalesce;
    assign pop  = mem_req_q && mem_ack;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == word)) begin
                hit = 1'b1;
            end
        end
    end

    assign cpu_stall  = (cpu_we && full && !coalesce) || (cpu_re && hit);
    assign misalign_d = cpu_we && !st_legal && !full;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end

        if (push) begin
            addr_d[tail_q]  = word;
            data_d[tail_q]  = st_data;
            be_d[tail_q]    = st_be;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end

        if (coalesce) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    data_d[tail_last][8*b +: 8] = st_data[8*b +: 8];
                end
            end
            be_d[tail_last] = be_q[tail_last] | st_be;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    // The output stage reloads from the post-update queue so back-to-back writes need no idle cycle.
    always_comb begin
        mem_req_d   = (count_d != '0);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if ((!mem_req_q || pop) && mem_req_d) begin
            mem_addr_d  = addr_d[head_d];
            mem_wdata_d = data_d[head_d];
            mem_be_d    = be_d[head_d];
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            misalign_q  <= misalign_d;
        end
    end

    // NOTE: the payload array is not reset; valid_q gates every use, so only the valid bits need clearing.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = {mem_addr_q, 2'b00};
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign misalign_err = misalign_q;
    assign count        = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4); coalescing checks follow STORE_COALESCE_EN.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic        cpu_stall, misalign_err;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    store_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_funct3   (cpu_funct3),
        .cpu_stall    (cpu_stall),
        .misalign_err (misalign_err),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        cpu_we     = 1'b1;
        cpu_addr   = a;
        cpu_wdata  = d;
        cpu_funct3 = f3;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; mem_ack = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
        #12;
        check("rst_count",    32'(count), 32'd0);
        check("rst_req",      32'(mem_req), 32'd0);
        check("rst_addr",     mem_addr, 32'h0);
        check("rst_wdata",    mem_wdata, 32'h0);
        check("rst_be",       32'(mem_be), 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        reset = 1'b1;
        step();

        // SW with ack tied high
        mem_ack = 1'b1;
        put(32'h1000, 32'hDEADBEEF, 3'b010);
        step();
        cpu_we = 1'b0;
        check("sw_req",   32'(mem_req), 32'd1);
        check("sw_addr",  mem_addr, 32'h1000);
        check("sw_be",    32'(mem_be), 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        check("sw_count_drained", 32'(count), 32'd0);
        check("sw_req_drop",      32'(mem_req), 32'd0);

        // SB to the top lane
        put(32'h2003, 32'h000000AB, 3'b000);
        step();
        cpu_we = 1'b0;
        check("sb_addr",  mem_addr, 32'h2000);
        check("sb_be",    32'(mem_be), 32'h8);
        check("sb_wdata", mem_wdata, 32'hABABABAB);
        step();

        // SH to upper half
        put(32'h2002, 32'h00001234, 3'b001);
        step();
        cpu_we = 1'b0;
        check("sh_be",    32'(mem_be), 32'hC);
        check("sh_wdata", mem_wdata, 32'h12341234);
        step();

        // misaligned SH, then illegal funct3
        put(32'h2001, 32'h00005678, 3'b001);
        step();
        cpu_we = 1'b0;
        check("mis_sh_pulse", 32'(misalign_err), 32'd1);
        check("mis_sh_count", 32'(count), 32'd0);
        step();
        check("mis_sh_clear", 32'(misalign_err), 32'd0);
        put(32'h2000, 32'h0, 3'b011);
        step();
        cpu_we = 1'b0;
        check("mis_f3_pulse", 32'(misalign_err), 32'd1);
        check("mis_f3_req",   32'(mem_req), 32'd0);
        step();

        // fill with ack held low, fifth store stalls
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010);
            #1;
            check("fill_nostall", 32'(cpu_stall), 32'd0);
            step();
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_head",  mem_addr, 32'h100);
        put(32'h110, 32'hA4, 3'b010);
        #1;
        check("full_stall", 32'(cpu_stall), 32'd1);
        step();
        check("full_held_count", 32'(count), 32'd4);
        mem_ack = 1'b1;
        #1;
        check("full_stall_ack", 32'(cpu_stall), 32'd1);
        step();
        mem_ack = 1'b0;
        check("pop_count",  32'(count), 32'd3);
        check("pop_next",   mem_addr, 32'h104);
        check("pop_nostall", 32'(cpu_stall), 32'd0);
        step();
        cpu_we = 1'b0;
        check("fifth_enq", 32'(count), 32'd4);
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_addr",  mem_addr, 32'h104 + 32'(4 * k));
            check("drain_wdata", mem_wdata, 32'hA1 + 32'(k));
            step();
        end
        mem_ack = 1'b0;
        check("drain_empty", 32'(count), 32'd0);
        check("drain_req",   32'(mem_req), 32'd0);

        // load hazard against a pending store
        put(32'h3000, 32'h1, 3'b010);
        step();
        cpu_we = 1'b0;
        cpu_re = 1'b1;
        cpu_addr = 32'h3002;
        #1;
        check("ld_hit_stall", 32'(cpu_stall), 32'd1);
        step();
        check("ld_hit_hold", 32'(cpu_stall), 32'd1);
        cpu_addr = 32'h3004;
        #1;
        check("ld_miss", 32'(cpu_stall), 32'd0);
        cpu_addr = 32'h3002;
        mem_ack = 1'b1;
        #1;
        check("ld_hit_inflight", 32'(cpu_stall), 32'd1);
        step();
        mem_ack = 1'b0;
        check("ld_after_ack", 32'(cpu_stall), 32'd0);
        cpu_re = 1'b0;

        // asynchronous reset mid-handshake
        for (int i = 0; i < 3; i++) begin
            put(32'h500 + 32'(4 * i), 32'h0, 3'b010);
            step();
        end
        cpu_we = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_req",   32'(mem_req), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        #4;
        reset = 1'b1;
        step();

        // byte stores to one word, ack low
        put(32'h4000, 32'h11, 3'b000);
        step();
        put(32'h4001, 32'h22, 3'b000);
        step();
        check("co_count2", 32'(count), 32'd2);
        put(32'h4002, 32'h33, 3'b000);
        step();
        cpu_we = 1'b0;
        check("co_head_be", 32'(mem_be), 32'h1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("co_next_addr", mem_addr, 32'h4000);
`ifdef STORE_COALESCE_EN
        check("co_count_after", 32'(count), 32'd1);
        check("co_be",    32'(mem_be), 32'h6);
        check("co_bytes", 32'(mem_wdata[23:8]), 32'h3322);
`else
        check("nc_count_after", 32'(count), 32'd2);
        check("nc_be",    32'(mem_be), 32'h2);
        check("nc_bytes", 32'(mem_wdata[23:8]), 32'h2222);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
